// File: rtl/timer_ctrl_if.sv
// Host command channel, ISI write port and interrupt signals of timer_ctrl.
interface timer_ctrl_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [31:0] CMD_DATA;
    logic        ACT;
    logic [7:0]  BE;
    logic [63:0] DI;
    logic        INTR;
    logic        IRQ_CLR;
    logic [7:0]  IRQ_CNT;
    logic        IRQ;
    logic        BUSY;
    logic        DONE;

    // Host side: issues commands, drives the interrupt, observes status.
    modport master (
        output CMD_VALID, CMD_OP, CMD_DATA, INTR, IRQ_CLR,
        input  CMD_READY, ACT, BE, DI, IRQ_CNT, IRQ, BUSY, DONE
    );

    // Controller side.
    modport slave (
        input  CMD_VALID, CMD_OP, CMD_DATA, INTR, IRQ_CLR,
        output CMD_READY, ACT, BE, DI, IRQ_CNT, IRQ, BUSY, DONE
    );
endinterface

// File: rtl/timer_ctrl.sv
// Timer controller: turns host commands into single-cycle ISI writes,
// counts interrupt edges and auto-stops the timer after a one-shot fires.
module timer_ctrl (
    input logic         CLK,
    input logic         RESET,
    timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_CONFIG  = 2'd0,
        OP_LOADCNT = 2'd1,
        OP_STOP    = 2'd2,
        OP_ONESHOT = 2'd3
    } op_t;

    state_t      state_q, state_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] di_q, di_d;
    logic        auto_q, auto_d;
    logic        armed_q, armed_d;
    logic        stop_pend_q, stop_pend_d;
    logic        intr_q;
    logic [7:0]  irq_cnt_q, irq_cnt_d;
    logic        accept;
    logic        intr_edge;
    op_t         op;

    assign op        = op_t'(bus.CMD_OP);
    assign intr_edge = bus.INTR & ~intr_q;

    // Next-state and write-payload capture for the IDLE/ISSUE/GUARD sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        be_d    = be_q;
        di_d    = di_q;
        auto_d  = auto_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop_pend_q) begin
                    // Auto-stop wins over any waiting host command.
                    state_d = ISSUE;
                    be_d    = 8'hF7;
                    di_d    = '0;
                    auto_d  = 1'b1;
                end else if (bus.CMD_VALID) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                    auto_d  = 1'b0;
                    case (op)
                        OP_LOADCNT: begin
                            be_d = 8'h0F;
                            di_d = {bus.CMD_DATA, 32'h0};
                        end
                        OP_STOP: begin
                            be_d = 8'hF7;
                            di_d = '0;
                        end
                        default: begin
                            // CONFIG and ONESHOT: scaler plus ENA/AR/SEL.
                            be_d = 8'hF0;
                            di_d = {32'h0, bus.CMD_DATA[31:29], 5'h00, bus.CMD_DATA[23:0]};
                        end
                    endcase
                end
            end
            ISSUE:   state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One-shot arming and pending auto-stop bookkeeping.
    always_comb begin
        armed_d     = armed_q;
        stop_pend_d = stop_pend_q;
        if (state_q == IDLE && stop_pend_q) begin
            stop_pend_d = 1'b0;
        end
        if (intr_edge && armed_q) begin
            armed_d     = 1'b0;
            stop_pend_d = 1'b1;
        end
        if (accept) begin
            case (op)
                OP_ONESHOT:        armed_d = 1'b1;
                OP_CONFIG, OP_STOP: armed_d = 1'b0;
                default:           armed_d = armed_d;
            endcase
        end
    end

    // Saturating interrupt edge counter; a clear coinciding with an edge keeps that edge.
    always_comb begin
        irq_cnt_d = irq_cnt_q;
        if (bus.IRQ_CLR) begin
            irq_cnt_d = intr_edge ? 8'd1 : 8'd0;
        end else if (intr_edge && irq_cnt_q != 8'hFF) begin
            irq_cnt_d = irq_cnt_q + 8'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            be_q        <= 8'hFF;
            di_q        <= '0;
            auto_q      <= 1'b0;
            armed_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            intr_q      <= 1'b0;
            irq_cnt_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            be_q        <= be_d;
            di_q        <= di_d;
            auto_q      <= auto_d;
            armed_q     <= armed_d;
            stop_pend_q <= stop_pend_d;
            intr_q      <= bus.INTR;
            irq_cnt_q   <= irq_cnt_d;
        end
    end

    // The ISI write is visible only in ISSUE; otherwise the port idles.
    assign bus.ACT       = (state_q == ISSUE);
    assign bus.BE        = bus.ACT ? be_q : 8'hFF;
    assign bus.DI        = bus.ACT ? di_q : 64'h0;
    assign bus.DONE      = (state_q == GUARD) && auto_q;
    assign bus.BUSY      = (state_q != IDLE) || stop_pend_q;
    assign bus.CMD_READY = (state_q == IDLE) && !stop_pend_q;
    assign bus.IRQ_CNT   = irq_cnt_q;
    assign bus.IRQ       = (irq_cnt_q != 8'd0);
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;
    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    timer_ctrl_if bus();

    timer_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) for CMD_READY, present one command, return in its ISSUE cycle.
    task automatic issue_cmd(input logic [1:0] op, input logic [31:0] data);
        int n;
        n = 0;
        while (!bus.CMD_READY && n < 10) begin
            step();
            n++;
        end
        if (!bus.CMD_READY) check("ready_timeout", 64'd0, 64'd1);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_DATA  = data;
        step();
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = 32'hDEAD_BEEF;
        bus.CMD_OP    = 2'd1;
    endtask

    initial begin
        int act_cnt;
        int done_cnt;
        logic [7:0]  seen_be;
        logic [63:0] seen_di;

        checks        = 0;
        failures      = 0;
        RESET         = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 2'd0;
        bus.CMD_DATA  = 32'h0;
        bus.INTR      = 1'b0;
        bus.IRQ_CLR   = 1'b0;

        // Reset state.
        repeat (2) step();
        check("rst_act",  64'(bus.ACT), 64'd0);
        check("rst_be",   64'(bus.BE), 64'hFF);
        check("rst_di",   bus.DI, 64'd0);
        check("rst_cnt",  64'(bus.IRQ_CNT), 64'd0);
        check("rst_irq",  64'(bus.IRQ), 64'd0);
        check("rst_done", 64'(bus.DONE), 64'd0);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        RESET = 1'b1;
        step();
        check("rst_ready", 64'(bus.CMD_READY), 64'd1);

        // CONFIG timing; payload must hold even though CMD_DATA changed after accept.
        issue_cmd(2'd0, 32'hA000_0010);
        check("cfg_act",   64'(bus.ACT), 64'd1);
        check("cfg_be",    64'(bus.BE), 64'hF0);
        check("cfg_di",    bus.DI, 64'h0000_0000_A000_0010);
        check("cfg_ready", 64'(bus.CMD_READY), 64'd0);
        step();
        check("cfg_guard_act", 64'(bus.ACT), 64'd0);
        check("cfg_guard_be",  64'(bus.BE), 64'hFF);
        check("cfg_guard_di",  bus.DI, 64'd0);
        check("cfg_guard_rdy", 64'(bus.CMD_READY), 64'd0);
        step();
        check("cfg_n3_ready", 64'(bus.CMD_READY), 64'd1);
        check("cfg_n3_busy",  64'(bus.BUSY), 64'd0);

        // CONFIG masks bits 28:24 of the payload.
        issue_cmd(2'd0, 32'hFFFF_FFFF);
        check("cfg_mask_di", bus.DI, 64'h0000_0000_E0FF_FFFF);

        // LOADCNT: one ACT cycle, upper word.
        issue_cmd(2'd1, 32'h1234_5678);
        check("ld_be", 64'(bus.BE), 64'h0F);
        check("ld_di", bus.DI, 64'h1234_5678_0000_0000);
        act_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.ACT) act_cnt++;
        end
        check("ld_act_cycles", 64'(act_cnt), 64'd1);

        // Host STOP: no DONE pulse.
        issue_cmd(2'd2, 32'hFFFF_FFFF);
        check("stop_be", 64'(bus.BE), 64'hF7);
        check("stop_di", bus.DI, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.DONE) done_cnt++;
        end
        check("stop_no_done", 64'(done_cnt), 64'd0);

        // ONESHOT then INTR held 5 cycles: one auto STOP, one DONE.
        issue_cmd(2'd3, 32'hA000_0010);
        check("os_be", 64'(bus.BE), 64'hF0);
        check("os_di", bus.DI, 64'h0000_0000_A000_0010);
        step();
        step();
        bus.INTR = 1'b1;
        act_cnt  = 0;
        done_cnt = 0;
        seen_be  = 8'h00;
        seen_di  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) bus.INTR = 1'b0;
            if (bus.ACT) begin
                act_cnt++;
                seen_be = bus.BE;
                seen_di = bus.DI;
            end
            if (bus.DONE) done_cnt++;
        end
        check("os_irq_cnt",   64'(bus.IRQ_CNT), 64'd1);
        check("os_irq",       64'(bus.IRQ), 64'd1);
        check("os_auto_acts", 64'(act_cnt), 64'd1);
        check("os_auto_be",   64'(seen_be), 64'hF7);
        check("os_auto_di",   seen_di, 64'd0);
        check("os_done_cnt",  64'(done_cnt), 64'd1);
        check("os_busy_after", 64'(bus.BUSY), 64'd0);
        bus.IRQ_CLR = 1'b1;
        step();
        bus.IRQ_CLR = 1'b0;
        check("clr_cnt", 64'(bus.IRQ_CNT), 64'd0);

        // Edge during GUARD of a host command while the next command is held.
        issue_cmd(2'd3, 32'h2000_0001);
        step();
        step();
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = 2'd1;
        bus.CMD_DATA  = 32'hCAFE_F00D;
        step();
        check("hold_first_be", 64'(bus.BE), 64'h0F);
        step();
        bus.INTR = 1'b1;
        step();
        check("hold_pend_ready", 64'(bus.CMD_READY), 64'd0);
        check("hold_pend_busy",  64'(bus.BUSY), 64'd1);
        step();
        check("hold_auto_act", 64'(bus.ACT), 64'd1);
        check("hold_auto_be",  64'(bus.BE), 64'hF7);
        step();
        bus.INTR = 1'b0;
        check("hold_auto_done", 64'(bus.DONE), 64'd1);
        step();
        check("hold_idle_ready", 64'(bus.CMD_READY), 64'd1);
        step();
        bus.CMD_VALID = 1'b0;
        check("hold_cmd_be", 64'(bus.BE), 64'h0F);
        check("hold_cmd_di", bus.DI, 64'hCAFE_F00D_0000_0000);
        step();
        step();

        // Saturation and clear priority.
        bus.IRQ_CLR = 1'b1;
        step();
        bus.IRQ_CLR = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.INTR = 1'b1;
            step();
            bus.INTR = 1'b0;
            step();
        end
        check("sat_cnt", 64'(bus.IRQ_CNT), 64'd255);
        bus.INTR    = 1'b1;
        bus.IRQ_CLR = 1'b1;
        step();
        bus.IRQ_CLR = 1'b0;
        bus.INTR    = 1'b0;
        check("clr_edge_cnt", 64'(bus.IRQ_CNT), 64'd1);
        step();
        bus.IRQ_CLR = 1'b1;
        step();
        bus.IRQ_CLR = 1'b0;
        check("clr_only_cnt", 64'(bus.IRQ_CNT), 64'd0);
        check("clr_only_irq", 64'(bus.IRQ), 64'd0);

        // Reset during ISSUE aborts the write; nothing issues afterwards.
        issue_cmd(2'd1, 32'h0BAD_0BAD);
        check("rsti_pre_act", 64'(bus.ACT), 64'd1);
        RESET = 1'b0;
        #1;
        check("rsti_act",  64'(bus.ACT), 64'd0);
        check("rsti_be",   64'(bus.BE), 64'hFF);
        check("rsti_di",   bus.DI, 64'd0);
        check("rsti_busy", 64'(bus.BUSY), 64'd0);
        step();
        RESET = 1'b1;
        act_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.ACT) act_cnt++;
        end
        check("rsti_no_act",  64'(act_cnt), 64'd0);
        check("rsti_ready",   64'(bus.CMD_READY), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
